// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // 1 ms at 50 MHz
    localparam int PS2_TIMEOUT_DEF = 50000;

endpackage

// File: rtl/ps2_sync_filt.sv
// 2-flop synchronizer plus run-length glitch filter; emits a one-cycle fall strobe.
// Latency: 2 sync cycles + FILTER_LEN samples from input edge to filtered edge.
// No backpressure: free-running sampler.
module ps2_sync_filt #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk50,
    input  logic reset,
    input  logic din,
    output logic filt,
    output logic fall
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk50) begin
        if (!reset) begin
            sync <= 2'b11;
            cnt  <= '0;
            filt <= 1'b1;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            fall <= 1'b0;
            // cnt tracks how many samples in a row have disagreed with filt
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
                fall <= filt;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard frame receiver (start, 8 data LSB first, odd parity, stop); PS2_BREAK_FILTER_EN drops break/extended codes.
// Latency: scan_vld / frame_err one clk50 cycle after the stop-bit fall (or timeout).
// No backpressure: scan_vld is a strobe, scan_data holds until the next byte.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = PS2_TIMEOUT_DEF
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       scan_vld,
    output logic [7:0] scan_data,
    output logic       frame_err
);

    localparam logic [15:0] TO_MAX = 16'(TIMEOUT_CYC - 1);

    logic       clk_filt;
    logic       clk_fall;
    logic [1:0] data_sync;
    logic       data_s;

    ps2_state_t state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shift_reg, shift_nxt;
    logic       par_bit, par_nxt;
    logic [15:0] to_cnt;
    logic       byte_ok, byte_bad, timeout;
    logic       emit;

    ps2_sync_filt #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filt (
        .clk50 (clk50),
        .reset (reset),
        .din   (ps2_clk),
        .filt  (clk_filt),
        .fall  (clk_fall)
    );

    always_ff @(posedge clk50) begin
        if (!reset) data_sync <= 2'b11;
        else        data_sync <= {data_sync[0], ps2_data};
    end
    assign data_s = data_sync[1];

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        par_nxt     = par_bit;
        byte_ok     = 1'b0;
        byte_bad    = 1'b0;
        timeout     = 1'b0;
        if (clk_fall) begin
            case (state)
                IDLE: begin
                    if (!data_s) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = 3'd0;
                    end
                end
                DATA: begin
                    shift_nxt   = {data_s, shift_reg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    par_nxt   = data_s;
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (data_s && (^{shift_reg, par_bit})) byte_ok  = 1'b1;
                    else                                   byte_bad = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && to_cnt == TO_MAX) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    logic break_pend, break_pend_nxt;

    // The byte following F0 is the released key; it is swallowed along with F0.
    always_comb begin
        emit           = 1'b0;
        break_pend_nxt = break_pend;
        if (byte_ok) begin
            if (break_pend)                   break_pend_nxt = 1'b0;
            else if (shift_reg == PS2_BREAK)  break_pend_nxt = 1'b1;
            else if (shift_reg != PS2_EXT)    emit           = 1'b1;
        end else if (byte_bad || timeout) begin
            break_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk50) begin
        if (!reset) break_pend <= 1'b0;
        else        break_pend <= break_pend_nxt;
    end
`else
    assign emit = byte_ok;
`endif

    always_ff @(posedge clk50) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            par_bit   <= 1'b0;
            to_cnt    <= 16'd0;
            scan_vld  <= 1'b0;
            scan_data <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
            par_bit   <= par_nxt;
            if (clk_fall || state == IDLE) to_cnt <= 16'd0;
            else                           to_cnt <= to_cnt + 16'd1;
            scan_vld  <= emit;
            frame_err <= byte_bad | timeout;
            if (emit) scan_data <= shift_reg;
        end
    end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Randomized PS/2 frame stimulus with a queue-based scoreboard and decoupled output monitor.
module tb_ps2_scan_rx;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 2000;

    logic       clk50;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       scan_vld;
    logic [7:0] scan_data;
    logic       frame_err;

    typedef struct {
        bit         is_err;
        logic [7:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   m_break = 0;

    ps2_scan_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk50     (clk50),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scan_vld  (scan_vld),
        .scan_data (scan_data),
        .frame_err (frame_err)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk50);
    endtask

    // Reference behaviour: a completed frame is good iff stop=1 and the
    // nine data+parity bits hold an odd number of ones.
    function automatic void model_byte(input logic [7:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.dat    = d;
`ifdef PS2_BREAK_FILTER_EN
        if (m_break)           m_break = 0;
        else if (d == 8'hF0)   m_break = 1;
        else if (d != 8'hE0)   exp_q.push_back(e);
`else
        exp_q.push_back(e);
`endif
    endfunction

    function automatic void model_err();
        exp_t e;
        e.is_err = 1'b1;
        e.dat    = 8'h00;
        m_break  = 0;
        exp_q.push_back(e);
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cyc(10);
            ps2_clk = 1'b0;
            wait_cyc(20);
            ps2_clk = 1'b1;
            wait_cyc(10);
        end
        ps2_data = 1'b1;
        wait_cyc(30);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic par, stop;
        par  = (($countones(d) % 2) == 0) ^ bad_par;
        stop = ~bad_stop;
        if (stop && (($countones(d) + par) % 2 == 1)) model_byte(d);
        else                                         model_err();
        send_bits({stop, par, d, 1'b0}, 11);
    endtask

    // Partial frame: start bit plus (nbits-1) further bits, then silence past the timeout.
    task automatic send_trunc(input logic [7:0] d, input int nbits);
        model_err();
        send_bits({1'b1, 1'b0, d, 1'b0}, nbits);
        wait_cyc(TIMEOUT_CYC + 100);
    endtask

    task automatic glitch(input int len);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        wait_cyc(len);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(20);
    endtask

    // Monitor: pops one expectation per DUT strobe.
    logic [7:0] last_byte = 8'h00;
    always @(negedge clk50) begin
        exp_t e;
        if (reset) begin
            if (scan_vld && frame_err) begin
                n_cmp++;
                n_bad++;
                $display("FAIL strobe_excl: scan_vld=1 frame_err=1 same cycle, required at most one");
            end else if (scan_vld) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL scan_vld: unexpected byte %02h, required no strobe", scan_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err || scan_data !== e.dat) begin
                        n_bad++;
                        $display("FAIL scan_vld: got byte %02h, required %s %02h",
                                 scan_data, e.is_err ? "frame_err" : "byte", e.dat);
                    end
                    if (!e.is_err) last_byte = e.dat;
                end
            end else if (frame_err) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL frame_err: unexpected error strobe, required no strobe");
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_err || scan_data !== last_byte) begin
                        n_bad++;
                        $display("FAIL frame_err: got err with scan_data=%02h, required %s (held data %02h)",
                                 scan_data, e.is_err ? "frame_err" : "byte", last_byte);
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input int idx);
        n_cmp++;
        if (scan_vld !== 1'b0 || scan_data !== 8'h00 || frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out[%0d]: vld=%b data=%02h err=%b, required 0/00/0",
                     idx, scan_vld, scan_data, frame_err);
        end
    endtask

    initial begin
        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(2);
        for (int i = 0; i < 3; i++) begin
            check_reset_outputs(i);
            wait_cyc(1);
        end
        reset = 1'b1;
        wait_cyc(20);

        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_trunc(8'h5A, 6);
        send_frame(8'h29, 1'b0, 1'b0);
        glitch(FILTER_LEN - 2);
        send_frame(8'h33, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1);

        // Reset in the middle of a frame discards it silently.
        send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5);
        reset = 1'b0;
        m_break = 0;
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(20);
        send_frame(8'h45, 1'b0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            logic [7:0] d;
            int         kind;
            d    = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 9);
            case (kind)
                0: send_frame(d, 1'b1, 1'b0);
                1: send_frame(d, 1'b0, 1'b1);
                2: send_trunc(d, $urandom_range(1, 10));
                3: begin
                    glitch($urandom_range(1, FILTER_LEN - 2));
                    send_frame(d, 1'b0, 1'b0);
                end
                4: send_frame(($urandom_range(0, 1) != 0) ? 8'hF0 : 8'hE0, 1'b0, 1'b0);
                default: send_frame(d, 1'b0, 1'b0);
            endcase
            wait_cyc($urandom_range(0, 50));
        end

        wait_cyc(200);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected strobes never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: number of consecutive equal samples needed to accept a new ps2_clk level.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000: clk50 cycles allowed between falling edges inside a frame (1 ms).
REQ-003 SHALL have port clk50, input, 1: system clock, 50 MHz.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset on clk50.
REQ-005 SHALL have port ps2_clk, input, 1: keyboard clock; asynchronous to clk50.
REQ-006 SHALL have port ps2_data, input, 1: keyboard data; asynchronous to clk50.
REQ-007 SHALL have port scan_vld, output, 1: one-cycle strobe marking a new scan byte.
REQ-008 SHALL have port scan_data, output, 8: last accepted scan byte.
REQ-009 SHALL have port frame_err, output, 1: one-cycle strobe on a parity, stop-bit or timeout error.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers.
REQ-011 SHALL update the filtered ps2_clk level only after FILTER_LEN consecutive identical synchronized samples; shorter glitches SHALL be ignored.
REQ-012 SHALL sample synchronized ps2_data on each 1-to-0 transition of the filtered clock ("fall").
REQ-013 SHALL implement states IDLE, DATA, PARITY and STOP.
REQ-014 IDLE: a fall with data=0 SHALL enter DATA with bit count 0; a fall with data=1 SHALL be ignored.
REQ-015 DATA: SHALL shift in 8 bits, LSB first, one per fall, and enter PARITY after the 8th bit.
REQ-016 PARITY: SHALL capture the parity bit on the next fall and enter STOP.
REQ-017 STOP: on the next fall, data=1 with odd parity over the 8 data bits plus parity bit SHALL accept the byte; any other case SHALL pulse frame_err; both cases SHALL return to IDLE.
REQ-018 SHALL assert scan_vld exactly one clk50 cycle after the accepting stop-bit fall, with scan_data updated in that same cycle.
REQ-019 scan_data SHALL hold its value until the next emitted byte.
REQ-020 SHALL clear a 16-bit timeout counter on every fall; outside IDLE, reaching TIMEOUT_CYC-1 SHALL force IDLE and pulse frame_err.
REQ-021 SHALL never assert scan_vld and frame_err in the same cycle.

Reset
REQ-022 While reset=0, outputs SHALL be: scan_vld=0, scan_data=8'h00, frame_err=0.
REQ-023 While reset=0, SHALL force state=IDLE, bit count=0, timeout counter=0, break/extended flags=0, filtered clock=1, synchronizers=1.
REQ-024 A reset asserted mid-frame SHALL discard the partial frame with no strobe on release.

Configuration
REQ-025 Macro PS2_BREAK_FILTER_EN SHALL select break-code filtering.
REQ-026 With PS2_BREAK_FILTER_EN defined: an accepted 8'hF0 SHALL set break_pend and not be emitted; the next accepted byte SHALL be discarded and clear break_pend; an accepted 8'hE0 SHALL not be emitted; frame_err SHALL clear break_pend.
REQ-027 Without PS2_BREAK_FILTER_EN: every accepted byte, including F0 and E0, SHALL be emitted on scan_vld/scan_data.

Structure
REQ-028 Package ps2_pkg SHALL hold the state enum, PS2_BREAK=8'hF0, PS2_EXT=8'hE0 and the default timeout constant.
REQ-029 Synchronizer plus glitch filter SHALL be sub-module ps2_sync_filt (parameter FILTER_LEN), instantiated once for ps2_clk; ps2_data SHALL use only the 2-flop synchronizer.

Verification
REQ-030 Frame 0x1C, parity 0, stop 1 -> single scan_vld, scan_data=0x1C, frame_err=0.
REQ-031 Frame 0x1C, parity 1 -> one frame_err pulse, no scan_vld, scan_data unchanged.
REQ-032 Bytes F0 then 1C -> with macro: no scan_vld; without macro: two strobes, 0xF0 then 0x1C.
REQ-033 Stop after 5 data bits, idle TIMEOUT_CYC cycles -> one frame_err; a following good 0x29 frame -> scan_vld, scan_data=0x29.
REQ-034 Low glitch on ps2_clk of FILTER_LEN-2 cycles during IDLE -> no state change, no strobes.
REQ-035 reset=0 for 2 cycles after 4 bits of 0x5A, then full frame 0x45 -> only 0x45 emitted.
